// File: rtl/cv32e40p_scnn_pkg.sv
// Shared types and constants for the SCNN GEMM tile scheduler.
//   scnn_seq_state_e : scheduler FSM states
//   SCNN_FLAG_*      : AGU start-flag encodings
//   TILE_DIM         : output tile edge (4x4 tiles)
//   WB_BEATS_*       : write-back beats per tile for int32 / int8 results
package cv32e40p_scnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_CFG = 3'd1,
        S_LOAD   = 3'd2,
        S_DRAIN  = 3'd3,
        S_WB_CFG = 3'd4,
        S_WB     = 3'd5,
        S_NEXT   = 3'd6
    } scnn_seq_state_e;

    localparam logic [1:0] SCNN_FLAG_IDLE = 2'b00;
    localparam logic [1:0] SCNN_FLAG_LOAD = 2'b10;
    localparam logic [1:0] SCNN_FLAG_WB   = 2'b01;

    localparam int unsigned TILE_DIM     = 4;
    localparam int unsigned WB_BEATS_I32 = 16;
    localparam int unsigned WB_BEATS_I8  = 4;

endpackage

// File: rtl/cv32e40p_scnn_seq_if.sv
// Scheduler <-> AGU/LSU/MAC bundle.
//   master : the scheduler (drives AGU controls, observes LSU beats and MAC done)
//   slave  : the AGU/LSU/MAC side
interface cv32e40p_scnn_seq_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DIM_W  = 16
);
    logic              data_req_i;
    logic              data_gnt_i;
    logic              mac_done_i;
    logic [1:0]        scnn_flag_o;
    logic [ADDR_W-1:0] addr_a_start_o;
    logic [ADDR_W-1:0] addr_b_start_o;
    logic [DIM_W-1:0]  gemm_m_o;
    logic [DIM_W-1:0]  gemm_n_o;
    logic [DIM_W-1:0]  gemm_k_o;
    logic              gemm4x4_active_o;
    logic              gemm_wb_active_o;
    logic              data_type_o;

    modport master (
        input  data_req_i, data_gnt_i, mac_done_i,
        output scnn_flag_o, addr_a_start_o, addr_b_start_o,
               gemm_m_o, gemm_n_o, gemm_k_o,
               gemm4x4_active_o, gemm_wb_active_o, data_type_o
    );

    modport slave (
        output data_req_i, data_gnt_i, mac_done_i,
        input  scnn_flag_o, addr_a_start_o, addr_b_start_o,
               gemm_m_o, gemm_n_o, gemm_k_o,
               gemm4x4_active_o, gemm_wb_active_o, data_type_o
    );
endinterface

// File: rtl/cv32e40p_scnn_tile_cnt.sv
// Row/column tile counter with wrap and last-tile detect.
//   clr/adv           : restart at tile (0,0) / step to the next tile
//   tiles_m/tiles_n   : tile rows (M/4) and tile columns (N/4)
//   row/col           : current tile indices (registered)
//   row_nxt_c/col_nxt_c, last_c : indices after the next advance, current tile is last
module cv32e40p_scnn_tile_cnt #(
    parameter int unsigned TW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    input  logic [TW-1:0] tiles_m,
    input  logic [TW-1:0] tiles_n,
    output logic [TW-1:0] row,
    output logic [TW-1:0] col,
    output logic [TW-1:0] row_nxt_c,
    output logic [TW-1:0] col_nxt_c,
    output logic          last_c
);

    logic col_wrap_c;

    // Column wraps at N/4; the row steps only on a column wrap.
    always_comb begin
        col_wrap_c = (col + TW'(1)) == tiles_n;
        col_nxt_c  = col_wrap_c ? '0 : col + TW'(1);
        row_nxt_c  = col_wrap_c ? row + TW'(1) : row;
        last_c     = col_wrap_c && (row_nxt_c == tiles_m);
    end

    // Indices return to (0,0) after the last tile so IDLE shows zeros.
    always_ff @(posedge clk) begin
        if (rst || clr || (adv && last_c)) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            row <= row_nxt_c;
            col <= col_nxt_c;
        end
    end

endmodule

// File: rtl/cv32e40p_scnn_seq.sv
// GEMM tile scheduler for the SCNN AGU: walks an MxN result as 4x4 tiles,
// issuing a load phase (2K beats) and a write-back phase per tile.
//   clk, rst            : clock, synchronous active-high reset
//   start_i, abort_i    : job request (IDLE only) / abort current job
//   cfg_*               : job bases, dimensions, result type
//   agu                 : AGU controls out, LSU req/gnt and MAC done in
//   busy_o              : job in progress
//   done_o, err_o       : one-cycle job-complete / bad-config pulses
//   tile_row_o/col_o    : current tile indices
module cv32e40p_scnn_seq
    import cv32e40p_scnn_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DIM_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [ADDR_W-1:0]    cfg_a_base_i,
    input  logic [ADDR_W-1:0]    cfg_b_base_i,
    input  logic [ADDR_W-1:0]    cfg_c_base_i,
    input  logic [DIM_W-1:0]     cfg_m_i,
    input  logic [DIM_W-1:0]     cfg_n_i,
    input  logic [DIM_W-1:0]     cfg_k_i,
    input  logic                 cfg_dtype_i,
    cv32e40p_scnn_seq_if.master  agu,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [DIM_W-3:0]     tile_row_o,
    output logic [DIM_W-3:0]     tile_col_o
);

    localparam int unsigned TW = DIM_W - 2;
    localparam int unsigned BW = DIM_W + 1;

    scnn_seq_state_e   state_q;
    logic [ADDR_W-1:0] a_q, b_q, c_q;
    logic [DIM_W-1:0]  m_q, n_q, k_q;
    logic              dtype_q;
    logic [BW-1:0]     beat_q;

    logic              beat_c, cfg_ok_c, ld_last_c, wb_last_c;
    logic              tile_clr_c, tile_adv_c, last_c;
    logic [TW-1:0]     row_nxt_c, col_nxt_c;
    logic [BW-1:0]     wb_target_c;
    logic [ADDR_W-1:0] a_nxt_c, b_nxt_c, wb_off_c, wb_addr_c;

    assign agu.gemm_m_o    = m_q;
    assign agu.gemm_n_o    = n_q;
    assign agu.gemm_k_o    = k_q;
    assign agu.data_type_o = dtype_q;

    // Beat qualification, config check and phase-exit decode.
    always_comb begin
        beat_c      = agu.data_req_i & agu.data_gnt_i;
        cfg_ok_c    = (cfg_m_i != '0) && (cfg_n_i != '0) && (cfg_k_i != '0) &&
                      (cfg_m_i[1:0] == 2'b00) && (cfg_n_i[1:0] == 2'b00);
        wb_target_c = dtype_q ? BW'(WB_BEATS_I8) : BW'(WB_BEATS_I32);
        ld_last_c   = beat_c && ((beat_q + BW'(1)) == {k_q, 1'b0});
        wb_last_c   = beat_c && ((beat_q + BW'(1)) == wb_target_c);
        tile_clr_c  = (state_q == S_IDLE) ? (start_i && !abort_i && cfg_ok_c) : abort_i;
        tile_adv_c  = (state_q == S_NEXT) && !abort_i;
    end

    // Start addresses; modular products are equivalent to full-width truncated.
    always_comb begin
        a_nxt_c  = a_q + ADDR_W'(TILE_DIM) * ADDR_W'(row_nxt_c);
        b_nxt_c  = b_q + ADDR_W'(TILE_DIM) * ADDR_W'(col_nxt_c);
        wb_off_c = ADDR_W'(TILE_DIM) *
                   (ADDR_W'(tile_row_o) * ADDR_W'(n_q) + ADDR_W'(tile_col_o));
        // int32 results occupy four bytes per element
        if (!dtype_q) wb_off_c = wb_off_c << 2;
        wb_addr_c = c_q + wb_off_c;
    end

    cv32e40p_scnn_tile_cnt #(.TW(TW)) u_tile_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (tile_clr_c),
        .adv       (tile_adv_c),
        .tiles_m   (m_q[DIM_W-1:2]),
        .tiles_n   (n_q[DIM_W-1:2]),
        .row       (tile_row_o),
        .col       (tile_col_o),
        .row_nxt_c (row_nxt_c),
        .col_nxt_c (col_nxt_c),
        .last_c    (last_c)
    );

    // Scheduler FSM; outputs are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= S_IDLE;
            beat_q               <= '0;
            a_q                  <= '0;
            b_q                  <= '0;
            c_q                  <= '0;
            m_q                  <= '0;
            n_q                  <= '0;
            k_q                  <= '0;
            dtype_q              <= 1'b0;
            busy_o               <= 1'b0;
            done_o               <= 1'b0;
            err_o                <= 1'b0;
            agu.scnn_flag_o      <= SCNN_FLAG_IDLE;
            agu.addr_a_start_o   <= '0;
            agu.addr_b_start_o   <= '0;
            agu.gemm4x4_active_o <= 1'b0;
            agu.gemm_wb_active_o <= 1'b0;
        end else begin
            agu.scnn_flag_o      <= SCNN_FLAG_IDLE;
            agu.addr_a_start_o   <= '0;
            agu.addr_b_start_o   <= '0;
            agu.gemm4x4_active_o <= 1'b0;
            agu.gemm_wb_active_o <= 1'b0;
            done_o               <= 1'b0;
            err_o                <= 1'b0;
            // abort wins everywhere, including over a start in IDLE
            if (abort_i) begin
                state_q <= S_IDLE;
                busy_o  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start_i) begin
                        a_q     <= cfg_a_base_i;
                        b_q     <= cfg_b_base_i;
                        c_q     <= cfg_c_base_i;
                        m_q     <= cfg_m_i;
                        n_q     <= cfg_n_i;
                        k_q     <= cfg_k_i;
                        dtype_q <= cfg_dtype_i;
                        if (cfg_ok_c) begin
                            state_q            <= S_LD_CFG;
                            busy_o             <= 1'b1;
                            agu.scnn_flag_o    <= SCNN_FLAG_LOAD;
                            agu.addr_a_start_o <= cfg_a_base_i;
                            agu.addr_b_start_o <= cfg_b_base_i;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    S_LD_CFG: begin
                        state_q              <= S_LOAD;
                        beat_q               <= '0;
                        agu.gemm4x4_active_o <= 1'b1;
                    end
                    S_LOAD: begin
                        if (beat_c) beat_q <= beat_q + BW'(1);
                        if (ld_last_c) state_q <= S_DRAIN;
                        else           agu.gemm4x4_active_o <= 1'b1;
                    end
                    S_DRAIN: if (agu.mac_done_i) begin
                        state_q            <= S_WB_CFG;
                        agu.scnn_flag_o    <= SCNN_FLAG_WB;
                        agu.addr_a_start_o <= wb_addr_c;
                    end
                    S_WB_CFG: begin
                        state_q              <= S_WB;
                        beat_q               <= '0;
                        agu.gemm_wb_active_o <= 1'b1;
                    end
                    S_WB: begin
                        if (beat_c) beat_q <= beat_q + BW'(1);
                        if (wb_last_c) state_q <= S_NEXT;
                        else           agu.gemm_wb_active_o <= 1'b1;
                    end
                    S_NEXT: begin
                        if (last_c) begin
                            state_q <= S_IDLE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            state_q            <= S_LD_CFG;
                            agu.scnn_flag_o    <= SCNN_FLAG_LOAD;
                            agu.addr_a_start_o <= a_nxt_c;
                            agu.addr_b_start_o <= b_nxt_c;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/cv32e40p_scnn_seq.md
# cv32e40p_scnn_seq

GEMM tile scheduler for the SCNN address-generation unit. Takes one GEMM job (A base, B base, C base, M, N, K, output type) and walks it as 4x4 output tiles. For each tile it drives the AGU's start flag, its load/write-back activity strobes and its start addresses. It sits between the SCNN custom-instruction decoder and the AGU in the EX stage, and counts granted LSU beats to decide phase completion.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DIM_W, 16, width of M/N/K.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  job request pulse; accepted only in IDLE.
- abort_i  in  1  abort the current job.
- cfg_a_base_i / cfg_b_base_i / cfg_c_base_i  in  ADDR_W  operand/result bases.
- cfg_m_i / cfg_n_i / cfg_k_i  in  DIM_W  GEMM dimensions.
- cfg_dtype_i  in  1  0 = int32 result, 1 = int8 result.
- data_req_i, data_gnt_i  in  1  LSU request/grant; a beat is req & gnt.
- mac_done_i  in  1  MAC array finished accumulating the current tile.
- scnn_flag_o  out  2  00 idle, 10 load-start, 01 write-back-start.
- addr_a_start_o / addr_b_start_o  out  ADDR_W  AGU start addresses.
- gemm_m_o / gemm_n_o / gemm_k_o  out  DIM_W  latched dimensions.
- gemm4x4_active_o, gemm_wb_active_o  out  1  AGU phase strobes.
- data_type_o  out  1  latched cfg_dtype_i.
- busy_o  out  1  not in IDLE.
- done_o, err_o  out  1  one-cycle completion / config-error pulses.
- tile_row_o, tile_col_o  out  DIM_W-2  current tile indices.

## Operation
- Reset value of every output is 0; the state resets to IDLE.
- IDLE: on start_i, latch the config.
  - Config is invalid if M, N or K is 0, or if M[1:0] or N[1:0] is nonzero. Invalid config pulses err_o, returns to IDLE, and produces no AGU activity.
  - Valid config clears row=col=0 and moves to LD_CFG.
- LD_CFG (1 cycle): scnn_flag_o=10.
  - addr_a_start_o = A + 4*row.
  - addr_b_start_o = B + 4*col.
  - Next state: LOAD; the beat counter is cleared.
- LOAD: gemm4x4_active_o=1; count beats. After 2*K beats, go to DRAIN.
- DRAIN: all strobes low; wait for mac_done_i, then go to WB_CFG.
- WB_CFG (1 cycle): scnn_flag_o=01.
  - addr_a_start_o = C + off, with off = 4*row*N + 4*col for dtype=1, and ×4 for dtype=0.
  - Next state: WB; the beat counter is cleared.
- WB: gemm_wb_active_o=1. Go to NEXT after 16 beats (dtype 0) or 4 beats (dtype 1).
- NEXT (1 cycle): advance the tile indices, then re-enter LD_CFG.
  - col++. When col wraps at N/4, col=0 and row++.
  - When row reaches M/4, go to IDLE with a done_o pulse instead.
- Arithmetic:
  - Address math is ADDR_W modular; wrap is not flagged.
  - Beat counter is DIM_W+1 bits.
  - Products are computed full-width and truncated to ADDR_W.
- abort_i in any non-IDLE state: next cycle IDLE, all strobes and flags 0, no done_o.
- Simultaneous events:
  - abort_i with start_i in IDLE: the start is ignored.
  - start_i while busy: ignored.
  - mac_done_i outside DRAIN: ignored.
  - Beats outside LOAD/WB: not counted.
- rst mid-job: identical to abort, plus the config registers are cleared.

## Timing
- start_i at edge 0: LD_CFG visible after edge 0. scnn_flag_o=10 and the start addresses are valid for exactly one cycle.
- gemm4x4_active_o rises the cycle after scnn_flag_o=10. It falls the cycle after the edge that registers the 2K-th beat.
- The last WB beat is followed by NEXT, then LD_CFG, so there are 2 idle strobe cycles between tiles.
- done_o is asserted the cycle after the final NEXT. busy_o drops in the same cycle.
- err_o is asserted one cycle after start_i. busy_o never rises.
- The beat counter increments on the same edge as the granted beat. Phase exit is decided combinationally from count+1 == target.

## Structure
- Shared package cv32e40p_scnn_pkg holds:
  - the state enum scnn_seq_state_e;
  - scnn_flag constants SCNN_FLAG_IDLE/LOAD/WB;
  - TILE_DIM=4 and WB_BEATS_I32=16, WB_BEATS_I8=4.
- One natural sub-module, cv32e40p_scnn_tile_cnt: row/col counter with wrap and last-tile detect.
- The top level holds the FSM, beat counter and address computation.

## Test plan
- Single tile: M=N=4, K=8, dtype=0, A=0x1000, B=0x2000, C=0x3000, gnt always 1, mac_done 3 cycles after LOAD ends.
  - Expect flag 10 with 0x1000/0x2000, 16 LOAD cycles, flag 01 with 0x3000, 16 WB cycles, one done_o.
- 2x2 tiles: M=N=8, K=4, dtype=1, C=0x4000.
  - Expect WB starts 0x4000, 0x4004, 0x4020, 0x4024.
  - Expect A starts +0,+0,+4,+4 and B starts +0,+4,+0,+4.
  - Expect 4 beats per WB.
- Grant stalls: randomly drop data_gnt_i in LOAD with K=5.
  - Exit occurs only after exactly 10 granted beats.
- Bad config: M=6 or K=0.
  - Expect err_o the next cycle, busy_o stays 0, no flag activity.
- Abort in LOAD and in DRAIN.
  - Next cycle: IDLE, all outputs 0, no done_o.
  - A following start completes normally.
- Reset asserted during WB.
  - Next cycle: every output 0.
  - start_i in the same cycle as rst is not accepted.
